// File: rtl/tick_sched_pkg.sv
// Shared types and default widths for the tick scheduler.
// Optional feature macro used by this block: TICK_SCHED_TOTAL_EN.
package tick_sched_pkg;

  localparam int DIV_W_DEF   = 26;
  localparam int BURST_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/tick_sched_if.sv
// Configuration/control/status bundle between a tick scheduler and its controller.
// TICK_SCHED_TOTAL_EN adds the tick_total status counter to the bundle.
interface tick_sched_if import tick_sched_pkg::*; #(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) ();

  logic               cfg_valid;
  logic               cfg_ready;
  logic [DIV_W-1:0]   cfg_div;
  logic [BURST_W-1:0] cfg_burst;
  logic               start;
  logic               pause;
  logic               stop;
  logic               tick;
  logic               busy;
  logic               done;
  logic [BURST_W-1:0] ticks_left;
`ifdef TICK_SCHED_TOTAL_EN
  logic [15:0]        tick_total;

  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, pause, stop,
    input  cfg_ready, tick, busy, done, ticks_left, tick_total
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, pause, stop,
    output cfg_ready, tick, busy, done, ticks_left, tick_total
  );
`else
  modport master (
    output cfg_valid, cfg_div, cfg_burst, start, pause, stop,
    input  cfg_ready, tick, busy, done, ticks_left
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_burst, start, pause, stop,
    output cfg_ready, tick, busy, done, ticks_left
  );
`endif

endinterface

// File: rtl/tick_divider.sv
// Rate-divider counter: counts 0..period_i while enabled and flags the wrap cycle.
module tick_divider import tick_sched_pkg::*; #(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             wrap_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == keeps the count bounded even if the period shrinks under it
  assign wrap_o = en_i && !clr_i && (cnt_q >= period_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_sched.sv
// Programmable tick scheduler: burst/continuous tick pulses with pause and stop.
// Define TICK_SCHED_TOTAL_EN to add the 16-bit tick_total run counter.
module tick_sched import tick_sched_pkg::*; #(
  parameter int DIV_W   = DIV_W_DEF,
  parameter int BURST_W = BURST_W_DEF
) (
  input logic         clk,
  input logic         resetn,
  tick_sched_if.slave bus
);

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [BURST_W-1:0] left_q, left_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               divEn, divClr, divWrap;
  logic               cfgFire, runStart;

  assign cfgFire  = bus.cfg_valid && (state_q == ST_IDLE);
  assign runStart = (state_q == ST_IDLE) && bus.start && !bus.stop;

  tick_divider #(.DIV_W(DIV_W)) u_divider (
    .clk      (clk),
    .resetn   (resetn),
    .en_i     (divEn),
    .clr_i    (divClr),
    .period_i (div_q),
    .wrap_o   (divWrap)
  );

  // Config is applied before the start decision so a same-cycle start sees the new burst
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    burst_d = burst_q;
    left_d  = left_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    divEn   = 1'b0;
    divClr  = 1'b0;

    if (cfgFire) begin
      div_d   = bus.cfg_div;
      burst_d = bus.cfg_burst;
      left_d  = bus.cfg_burst;
    end

    case (state_q)
      ST_IDLE: begin
        if (runStart) begin
          state_d = ST_RUN;
          divClr  = 1'b1;
          left_d  = burst_d;
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (bus.stop) begin
          state_d = ST_IDLE;
          divClr  = 1'b1;
          left_d  = '0;
        end else if (bus.pause) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
          divEn   = 1'b1;
          if (divWrap) begin
            tick_d = 1'b1;
            if (burst_q != '0) begin
              left_d = left_q - BURST_W'(1);
              if (left_q == BURST_W'(1)) begin
                done_d  = 1'b1;
                state_d = ST_DONE;
              end
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        divClr  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        divClr  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      burst_q <= '0;
      left_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      burst_q <= burst_d;
      left_q  <= left_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign bus.cfg_ready  = (state_q == ST_IDLE);
  assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign bus.tick       = tick_q;
  assign bus.done       = done_q;
  assign bus.ticks_left = left_q;

`ifdef TICK_SCHED_TOTAL_EN
  logic [15:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if (runStart) begin
      total_d = '0;
    end else if (tick_d) begin
      total_d = total_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign bus.tick_total = total_q;
`endif

endmodule

// File: tb/tb_tick_sched.sv
// Scoreboarded bench for tick_sched; expected tick events are queued at start and
// retired by a negedge monitor. Define TICK_SCHED_TOTAL_EN to also exercise tick_total.
module tb_tick_sched;
  import tick_sched_pkg::*;

  localparam int DIV_W   = 26;
  localparam int BURST_W = 8;

  typedef struct {
    int                 cyc;
    logic [BURST_W-1:0] left;
    logic               done;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t expQ[$];

  tick_sched_if #(.DIV_W(DIV_W), .BURST_W(BURST_W)) bus ();

  tick_sched #(.DIV_W(DIV_W), .BURST_W(BURST_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Retires one queued expectation per observed tick/done pulse
  task automatic scoreTicks();
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn === 1'b1 && (bus.tick === 1'b1 || bus.done === 1'b1)) begin
        if (expQ.size() == 0) begin
          vectors++; miscompares++;
          $display("[TB] FAIL unexpected_pulse cyc=%0d tick=%b done=%b want no pulse", cyc, bus.tick, bus.done);
        end else begin
          e = expQ.pop_front();
          vectors++;
          if (cyc !== e.cyc) begin
            miscompares++;
            $display("[TB] FAIL tick_cycle got=%0d want=%0d", cyc, e.cyc);
          end
          vectors++;
          if (bus.tick !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL tick_level cyc=%0d got=%b want=1", cyc, bus.tick);
          end
          vectors++;
          if (bus.ticks_left !== e.left) begin
            miscompares++;
            $display("[TB] FAIL tick_left cyc=%0d got=%0d want=%0d", cyc, bus.ticks_left, e.left);
          end
          vectors++;
          if (bus.done !== e.done) begin
            miscompares++;
            $display("[TB] FAIL tick_done cyc=%0d got=%b want=%b", cyc, bus.done, e.done);
          end
        end
      end
    end
  endtask

  task automatic doConfig(input logic [DIV_W-1:0] d, input logic [BURST_W-1:0] b);
    @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = d;
    bus.cfg_burst = b;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic startRun(output int c0);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    c0 = cyc;
  endtask

  task automatic test_reset();
    #12;
    vectors++;
    if (bus.tick !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_pulses got tick=%b done=%b busy=%b want 0/0/0", bus.tick, bus.done, bus.busy);
    end
    vectors++;
    if (bus.ticks_left !== '0 || bus.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_status got left=%0d ready=%b want 0/1", bus.ticks_left, bus.cfg_ready);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_burst();
    int c0;
    @(negedge clk);
    vectors++;
    if (bus.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL burst_ready_idle got=%b want=1", bus.cfg_ready);
    end
    doConfig(26'd3, 8'd4);
    startRun(c0);
    for (int i = 1; i <= 4; i++) begin
      expQ.push_back('{cyc: c0 + 4 * i, left: BURST_W'(4 - i), done: (i == 4)});
    end
    vectors++;
    if (bus.ticks_left !== 8'd4 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL burst_start got left=%0d busy=%b want 4/1", bus.ticks_left, bus.busy);
    end
    repeat (17) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.ticks_left !== '0) begin
      miscompares++;
      $display("[TB] FAIL burst_end got busy=%b done=%b ready=%b left=%0d want 0/0/1/0",
               bus.busy, bus.done, bus.cfg_ready, bus.ticks_left);
    end
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL burst_missing got=%0d pending want=0", expQ.size());
    end
    expQ.delete();
  endtask

  task automatic test_continuous();
    int c0;
    doConfig(26'd0, 8'd0);
    startRun(c0);
    for (int i = 1; i <= 10; i++) begin
      expQ.push_back('{cyc: c0 + i, left: '0, done: 1'b0});
    end
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.ticks_left !== '0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cont_midrun got left=%0d busy=%b want 0/1", bus.ticks_left, bus.busy);
    end
    repeat (5) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.tick !== 1'b0 || bus.done !== 1'b0 || bus.ticks_left !== '0) begin
      miscompares++;
      $display("[TB] FAIL cont_stop got busy=%b tick=%b done=%b left=%0d want 0/0/0/0",
               bus.busy, bus.tick, bus.done, bus.ticks_left);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL cont_missing got=%0d pending want=0", expQ.size());
    end
    expQ.delete();
  endtask

  task automatic test_pause();
    int c0;
    doConfig(26'd5, 8'd2);
    startRun(c0);
    expQ.push_back('{cyc: c0 + 9,  left: 8'd1, done: 1'b0});
    expQ.push_back('{cyc: c0 + 15, left: 8'd0, done: 1'b1});
    repeat (2) @(negedge clk);
    bus.pause = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.ticks_left !== 8'd2 || bus.busy !== 1'b1 || bus.tick !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL pause_hold k=%0d got left=%0d busy=%b tick=%b want 2/1/0",
                 k, bus.ticks_left, bus.busy, bus.tick);
      end
    end
    bus.pause = 1'b0;
    repeat (12) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL pause_end got busy=%b pending=%0d want 0/0", bus.busy, expQ.size());
    end
    expQ.delete();
  endtask

  task automatic test_priority_cfg_lock();
    int c0;
    doConfig(26'd7, 8'd3);
    startRun(c0);
    repeat (2) @(negedge clk);
    bus.cfg_valid = 1'b1;
    bus.cfg_div   = 26'd1;
    bus.cfg_burst = 8'd9;
    vectors++;
    if (bus.cfg_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lock_ready got=%b want=0", bus.cfg_ready);
    end
    @(negedge clk);
    bus.cfg_valid = 1'b0;
    bus.start = 1'b1;
    bus.pause = 1'b1;
    bus.stop  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.stop  = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1 || bus.ticks_left !== '0) begin
      miscompares++;
      $display("[TB] FAIL prio_stop got busy=%b ready=%b left=%0d want 0/1/0",
               bus.busy, bus.cfg_ready, bus.ticks_left);
    end
    startRun(c0);
    expQ.push_back('{cyc: c0 + 8, left: 8'd2, done: 1'b0});
    vectors++;
    if (bus.ticks_left !== 8'd3) begin
      miscompares++;
      $display("[TB] FAIL lock_burst got=%0d want=3", bus.ticks_left);
    end
    repeat (9) @(negedge clk);
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL lock_end got busy=%b pending=%0d want 0/0", bus.busy, expQ.size());
    end
    expQ.delete();
  endtask

  task automatic test_reset_mid_burst();
    int c0;
    doConfig(26'd1, 8'd4);
    startRun(c0);
    expQ.push_back('{cyc: c0 + 2, left: 8'd3, done: 1'b0});
    expQ.push_back('{cyc: c0 + 4, left: 8'd2, done: 1'b0});
    repeat (5) @(negedge clk);
    vectors++;
    if (bus.ticks_left !== 8'd2) begin
      miscompares++;
      $display("[TB] FAIL rst_pre got left=%0d want=2", bus.ticks_left);
    end
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (bus.busy !== 1'b0 || bus.tick !== 1'b0 || bus.done !== 1'b0 ||
        bus.ticks_left !== '0 || bus.cfg_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rst_async got busy=%b tick=%b done=%b left=%0d ready=%b want 0/0/0/0/1",
               bus.busy, bus.tick, bus.done, bus.ticks_left, bus.cfg_ready);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    vectors++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL rst_after got done=%b busy=%b pending=%0d want 0/0/0",
               bus.done, bus.busy, expQ.size());
    end
    expQ.delete();
  endtask

`ifdef TICK_SCHED_TOTAL_EN
  task automatic test_total();
    int c0;
    doConfig(26'd1, 8'd3);
    startRun(c0);
    expQ.push_back('{cyc: c0 + 2, left: 8'd2, done: 1'b0});
    expQ.push_back('{cyc: c0 + 4, left: 8'd1, done: 1'b0});
    expQ.push_back('{cyc: c0 + 6, left: 8'd0, done: 1'b1});
    repeat (7) @(negedge clk);
    vectors++;
    if (bus.tick_total !== 16'd3) begin
      miscompares++;
      $display("[TB] FAIL total_burst got=%0d want=3", bus.tick_total);
    end
    startRun(c0);
    bus.stop = 1'b1;
    vectors++;
    if (bus.tick_total !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL total_clear got=%0d want=0", bus.tick_total);
    end
    @(negedge clk);
    bus.stop = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL total_missing got=%0d pending want=0", expQ.size());
    end
    expQ.delete();
  endtask
`endif

  initial begin
    resetn        = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_div   = '0;
    bus.cfg_burst = '0;
    bus.start     = 1'b0;
    bus.pause     = 1'b0;
    bus.stop      = 1'b0;
    fork
      scoreTicks();
    join_none
    test_reset();
    test_burst();
    test_continuous();
    test_pause();
    test_priority_cfg_lock();
    test_reset_mid_burst();
`ifdef TICK_SCHED_TOTAL_EN
    test_total();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
